// File: rtl/alu_issue_queue.sv
// Instruction FIFO in front of the 4-bit combinational ALU with a registered
// result stage; opcodes the ALU does not define are flagged and zeroed.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic [3:0]       out_opcode,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  OP_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         out_result_q, out_result_d;
  logic [3:0]         out_opcode_q, out_opcode_d;
  logic               out_illegal_q, out_illegal_d;

  logic               push, pop, not_empty;
  entry_t             head;

  // Handshake qualifiers and head-of-queue drive to the ALU
  always_comb begin
    not_empty  = (count_q != '0);
    in_ready   = (count_q < CNT_W'(DEPTH));
    push       = in_valid && in_ready;
    pop        = not_empty && (!out_valid_q || out_ready);
    head       = mem_q[rd_ptr_q];
    alu_opcode = not_empty ? head.opcode : 4'd0;
    alu_a      = not_empty ? head.a      : 4'd0;
    alu_b      = not_empty ? head.b      : 4'd0;
  end

  // Next-state for pointers, occupancy and the result stage
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_opcode_d  = out_opcode_q;
    out_illegal_d = out_illegal_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      out_valid_d  = 1'b1;
      out_opcode_d = head.opcode;
      // ALU output is undefined for opcodes above 5, so never sample it then
      if (head.opcode > OP_MAX) begin
        out_result_d  = 4'd0;
        out_illegal_d = 1'b1;
      end else begin
        out_result_d  = alu_result;
        out_illegal_d = 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_opcode_q  <= '0;
      out_illegal_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_opcode_q  <= out_opcode_d;
      out_illegal_q <= out_illegal_d;
      if (push) mem_q[wr_ptr_q] <= '{opcode: in_opcode, a: in_a, b: in_b};
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_opcode  = out_opcode_q;
  assign out_illegal = out_illegal_q;
  assign count       = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed scenarios plus random traffic,
// with a negedge monitor checking every presented result against a reference.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode, in_a, in_b;
  logic [3:0]       alu_opcode, alu_a, alu_b, alu_result;
  logic             out_valid, out_ready, out_illegal;
  logic [3:0]       out_result, out_opcode;
  logic [CNT_W-1:0] count;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t pend[$];
  exp_t last_exp;
  logic fresh = 1'b1;

  alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  // Spec-level result of an instruction; opcodes above 5 are illegal and read 0
  function automatic exp_t ref_model(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.ill = 1'b0;
    case (op)
      4'd0: e.res = 4'd0;
      4'd1: e.res = ~a;
      4'd2: e.res = ~b;
      4'd3: e.res = a | b;
      4'd4: e.res = a & b;
      4'd5: e.res = a ^ b;
      default: begin e.res = 4'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // External ALU; a junk pattern stands in for its undefined outputs
  always_comb begin
    case (alu_opcode)
      4'd0: alu_result = 4'd0;
      4'd1: alu_result = ~alu_a;
      4'd2: alu_result = ~alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a & alu_b;
      4'd5: alu_result = alu_a ^ alu_b;
      default: alu_result = 4'b1010;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Monitor: record accepted instructions, pop on each newly presented result
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      fresh = 1'b1;
    end else begin
      if (out_valid && fresh) begin
        if (pend.size() == 0) begin
          chk("unexpected_result", 32'(out_result), 32'hffff_ffff);
        end else begin
          last_exp = pend.pop_front();
          chk("sb_result", 32'(out_result), 32'(last_exp.res));
          chk("sb_opcode", 32'(out_opcode), 32'(last_exp.op));
          chk("sb_illegal", 32'(out_illegal), 32'(last_exp.ill));
        end
      end else if (out_valid) begin
        chk("hold_result", 32'(out_result), 32'(last_exp.res));
        chk("hold_opcode", 32'(out_opcode), 32'(last_exp.op));
      end
      chk("count_model", 32'(count), 32'(pend.size()));
      chk("in_ready_model", 32'(in_ready), 32'(pend.size() < DEPTH));
      if (pend.size() > 0)
        chk("alu_head", 32'({alu_opcode, alu_a, alu_b}),
            32'({pend[0].op, pend[0].a, pend[0].b}));
      else
        chk("alu_idle", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
      if (in_valid && in_ready) pend.push_back(ref_model(in_opcode, in_a, in_b));
      fresh = !out_valid || out_ready;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic acc;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    for (int g = 0; g < 50; g++) begin
      acc = in_ready;
      step();
      if (acc) break;
      if (g == 49) chk("push_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Single op: visible one edge after acceptance
    out_ready = 1'b1;
    push(4'd3, 4'b1010, 4'b0101);
    chk("single_count_n", 32'(count), 32'd1);
    chk("single_valid_n", 32'(out_valid), 32'd0);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_result", 32'(out_result), 32'b1111);
    chk("single_opcode", 32'(out_opcode), 32'd3);
    chk("single_illegal", 32'(out_illegal), 32'd0);
    chk("single_count", 32'(count), 32'd0);
    step();

    // Fill under backpressure, hold, then drain
    out_ready = 1'b0;
    push(4'd1, 4'b1100, 4'b1010);
    push(4'd2, 4'b1100, 4'b1010);
    push(4'd4, 4'b1100, 4'b1010);
    push(4'd5, 4'b1100, 4'b1010);
    push(4'd0, 4'b1100, 4'b1010);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_result", 32'(out_result), 32'b0011);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(out_result), 32'b0011);
    end
    out_ready = 1'b1;
    step();
    chk("drain1_result", 32'(out_result), 32'b0101);
    step();
    chk("drain2_result", 32'(out_result), 32'b1000);
    step();
    chk("drain3_result", 32'(out_result), 32'b0110);
    step();
    chk("drain4_result", 32'(out_result), 32'b0000);
    chk("drain_count", 32'(count), 32'd0);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Illegal opcode
    push(4'd9, 4'b1111, 4'b0000);
    step();
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_result", 32'(out_result), 32'd0);
    chk("illegal_opcode", 32'(out_opcode), 32'd9);
    step();

    // Back-to-back legal stream, pointers wrap several times
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_opcode = 4'($urandom_range(0, 5)); in_a = 4'($urandom); in_b = 4'($urandom);
      step();
      chk("stream_count_le1", 32'(count <= 1), 32'd1);
    end
    in_valid = 1'b0;
    step(); step(); step();

    // Random mixed traffic with random backpressure and all opcodes
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_opcode = 4'($urandom); in_a = 4'($urandom); in_b = 4'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("random_drained", 32'(count), 32'd0);

    // Asynchronous reset mid-stream with 3 queued and a held result
    out_ready = 1'b0;
    push(4'd3, 4'd1, 4'd2);
    push(4'd4, 4'd3, 4'd6);
    push(4'd5, 4'd7, 4'd2);
    push(4'd1, 4'd5, 4'd0);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_result", 32'(out_result), 32'd0);
    chk("arst_opcode", 32'(out_opcode), 32'd0);
    chk("arst_illegal", 32'(out_illegal), 32'd0);
    chk("arst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // First edge after release accepts a push
    out_ready = 1'b1;
    push(4'd5, 4'b1001, 4'b0011);
    chk("post_rst_count", 32'(count), 32'd1);
    step();
    chk("post_rst_result", 32'(out_result), 32'b1010);
    for (int i = 0; i < 4; i++) step();
    chk("final_pending", 32'(pend.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
